// File: rtl/match_pkg.sv
// rtl/match_pkg.sv - shared constants, tx state encoding and byte helper for the match-record link
package match_pkg;

    localparam int REC_W  = 60;
    localparam int COOR_W = 20;

    localparam logic [7:0] HDR0 = 8'hA5;
    localparam logic [7:0] HDR1 = 8'h5A;
    localparam logic [7:0] TRL  = 8'hEE;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_REC,
        S_WAIT,
        S_TRL,
        S_CNT_H,
        S_CNT_L,
        S_STAT,
        S_CSUM
    } tx_state_t;

    // Byte i of a record padded to 64 bits, byte 0 being the most significant.
    function automatic logic [7:0] rec_byte(logic [REC_W-1:0] rec, logic [2:0] idx);
        logic [63:0] word;
        word = {4'b0000, rec} << (8 * int'(idx));
        return word[63:56];
    endfunction

endpackage

// File: rtl/match_result_tx_if.sv
// rtl/match_result_tx_if.sv - record input, byte stream and status signals of match_result_tx
interface match_result_tx_if;
    import match_pkg::*;

    logic [REC_W-1:0] rec_din;
    logic             rec_valid;
    logic             match_done;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic             frame_done;
    logic             overflow;

    modport master (
        input  rec_din, rec_valid, match_done, tx_ready,
        output tx_data, tx_valid, busy, frame_done, overflow
    );

    modport slave (
        output rec_din, rec_valid, match_done, tx_ready,
        input  tx_data, tx_valid, busy, frame_done, overflow
    );
endinterface

// File: rtl/match_rec_fifo.sv
// rtl/match_rec_fifo.sv - show-ahead synchronous record FIFO; a push into a full FIFO lands if a pop
// happens on the same edge
module match_rec_fifo #(
    parameter int W  = 60,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  level
);
    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = cnt[AW];
    assign empty = (cnt == '0);
    assign level = cnt;
endmodule

// File: rtl/match_result_tx.sv
// rtl/match_result_tx.sv - buffers matcher records and frames them as header, 8-byte records and
// count/status/checksum trailer on a valid/ready byte stream
module match_result_tx #(
    parameter int         FIFO_AW = 4,
    parameter logic [7:0] HDR0    = match_pkg::HDR0,
    parameter logic [7:0] HDR1    = match_pkg::HDR1,
    parameter logic [7:0] TRL     = match_pkg::TRL
) (
    input logic               clk,
    input logic               rst,
    match_result_tx_if.master bus
);
    import match_pkg::*;

    tx_state_t        state;
    tx_state_t        state_n;
    logic [2:0]       idx;
    logic [15:0]      count;
    logic [7:0]       csum;
    logic             done_pending;
    logic             ovf;
    logic             ovf_next;

    logic [REC_W-1:0] rec;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] level;

    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             accept;
    logic             pop;
    logic             push_ok;
    logic             drop;
    logic             avail_next;
    logic             in_trailer;
    logic             frame_done;
    tx_state_t        next_sel;

    match_rec_fifo #(.W(REC_W), .AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.rec_valid),
        .pop   (pop),
        .din   (bus.rec_din),
        .dout  (rec),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign accept     = tx_valid && bus.tx_ready;
    assign pop        = (state == S_REC) && (idx == 3'd7) && accept;
    assign push_ok    = bus.rec_valid && (!fifo_full || pop);
    assign drop       = bus.rec_valid && fifo_full && !pop;
    // A record is available next cycle unless the FIFO drains on this edge with no refill.
    assign avail_next = push_ok || (level > (FIFO_AW+1)'(pop));
    assign in_trailer = state inside {S_TRL, S_CNT_H, S_CNT_L, S_STAT, S_CSUM};
    assign next_sel   = avail_next ? S_REC : (done_pending ? S_TRL : S_WAIT);
    assign frame_done = (state == S_CSUM) && accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state)
            S_IDLE: begin
                if (!fifo_empty || done_pending) state_n = S_HDR0;
            end
            S_HDR0: begin
                tx_valid = 1'b1;
                tx_data  = HDR0;
                if (accept) state_n = S_HDR1;
            end
            S_HDR1: begin
                tx_valid = 1'b1;
                tx_data  = HDR1;
                if (accept) state_n = next_sel;
            end
            S_REC: begin
                tx_valid = 1'b1;
                tx_data  = rec_byte(rec, idx);
                if (pop) state_n = next_sel;
            end
            S_WAIT: begin
                state_n = next_sel;
            end
            S_TRL: begin
                tx_valid = 1'b1;
                tx_data  = TRL;
                if (accept) state_n = S_CNT_H;
            end
            S_CNT_H: begin
                tx_valid = 1'b1;
                tx_data  = count[15:8];
                if (accept) state_n = S_CNT_L;
            end
            S_CNT_L: begin
                tx_valid = 1'b1;
                tx_data  = count[7:0];
                if (accept) state_n = S_STAT;
            end
            S_STAT: begin
                tx_valid = 1'b1;
                tx_data  = {7'b0, ovf};
                if (accept) state_n = S_CSUM;
            end
            S_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum;
                if (accept) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx          <= '0;
            count        <= '0;
            csum         <= '0;
            done_pending <= 1'b0;
            ovf          <= 1'b0;
            ovf_next     <= 1'b0;
        end else begin
            if ((state == S_REC) && accept) begin
                idx <= idx + 1'b1;
            end

            // A fresh pulse wins over the clear so a run ending during the trailer is not lost.
            if (bus.match_done) begin
                done_pending <= 1'b1;
            end else if ((state_n == S_TRL) && (state != S_TRL)) begin
                done_pending <= 1'b0;
            end

            if (frame_done) begin
                csum <= '0;
            end else if (accept && (state inside {S_REC, S_CNT_H, S_CNT_L, S_STAT})) begin
                csum <= csum ^ tx_data;
            end

            if (frame_done) begin
                count <= '0;
            end else if (pop && (count != 16'hFFFF)) begin
                count <= count + 16'd1;
            end

            // Drops while the trailer is going out are reported in the next frame's STAT byte.
            if (frame_done) begin
                ovf      <= ovf_next || drop;
                ovf_next <= 1'b0;
            end else if (drop) begin
                if (in_trailer) begin
                    ovf_next <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    assign bus.tx_data    = tx_data;
    assign bus.tx_valid   = tx_valid;
    assign bus.frame_done = frame_done;
    assign bus.overflow   = ovf;
    assign bus.busy       = (state != S_IDLE) || !fifo_empty || done_pending;
endmodule

// File: tb/tb_match_result_tx.sv
// tb/tb_match_result_tx.sv - directed self-checking bench for match_result_tx framing
module tb_match_result_tx;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    match_result_tx_if bus ();

    match_result_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         fd_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] ecsum;

    localparam logic [59:0] R0 = 60'h123456789ABCDEF;
    localparam logic [59:0] R1 = 60'hFEDCBA987654321;
    localparam logic [59:0] R2 = 60'h0F0F0F0F0F0F0F0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
        if (!rst && bus.frame_done) fd_cnt++;
    end

    function automatic logic [59:0] pat(input int i);
        return 60'h0A1B2C3D4E5F607 + 60'(i) * 60'h111111111111111;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_clear();
        exp_q.delete();
        got_q.delete();
        ecsum  = 8'h00;
        fd_cnt = 0;
    endtask

    task automatic exp_hdr();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
    endtask

    task automatic exp_rec(input logic [59:0] r);
        logic [63:0] w;
        w = {4'h0, r};
        for (int i = 7; i >= 0; i--) begin
            exp_q.push_back(w[i*8 +: 8]);
            ecsum ^= w[i*8 +: 8];
        end
    endtask

    task automatic exp_trl(input logic [15:0] cnt, input logic ovf);
        exp_q.push_back(8'hEE);
        exp_q.push_back(cnt[15:8]);
        exp_q.push_back(cnt[7:0]);
        exp_q.push_back({7'b0, ovf});
        ecsum ^= cnt[15:8] ^ cnt[7:0] ^ {7'b0, ovf};
        exp_q.push_back(ecsum);
    endtask

    task automatic send_rec(input logic [59:0] r, input logic done);
        bus.rec_din    = r;
        bus.rec_valid  = 1'b1;
        bus.match_done = done;
        tick();
        bus.rec_valid  = 1'b0;
        bus.match_done = 1'b0;
    endtask

    task automatic pulse_done();
        bus.match_done = 1'b1;
        tick();
        bus.match_done = 1'b0;
    endtask

    task automatic wait_bytes(input string tag, input int n);
        int k = 0;
        while (got_q.size() < n && k < 500) begin
            tick();
            k++;
        end
        check({tag, "_reach_byte"}, 64'(got_q.size()), 64'(n));
    endtask

    task automatic cmp_frame(input string tag);
        check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i),
                  (i < got_q.size()) ? {56'b0, got_q[i]} : 64'hDEAD, {56'b0, exp_q[i]});
        end
    endtask

    task automatic wait_frame(input string tag, output logic busy_at_fd, output logic busy_after);
        int k = 0;
        while (!bus.frame_done && k < 3000) begin
            tick();
            k++;
        end
        check({tag, "_fd_seen"}, 64'(bus.frame_done), 64'd1);
        busy_at_fd = bus.busy;
        tick();
        busy_after = bus.busy;
        repeat (4) tick();
        check({tag, "_fd_count"}, 64'(fd_cnt), 64'd1);
        cmp_frame(tag);
    endtask

    initial begin
        logic       b0, b1;
        logic [7:0] d0;
        logic       v0;
        int         bad;

        rst            = 1'b1;
        bus.rec_din    = '0;
        bus.rec_valid  = 1'b0;
        bus.match_done = 1'b0;
        bus.tx_ready   = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        check("rst_tx_data", 64'(bus.tx_data), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_frame_done", 64'(bus.frame_done), 64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);

        // Three records, then match_done; includes two-cycle latency to the first header byte.
        exp_clear();
        exp_hdr();
        exp_rec(R0);
        exp_rec(R1);
        exp_rec(R2);
        exp_trl(16'd3, 1'b0);
        bus.rec_din   = R0;
        bus.rec_valid = 1'b1;
        tick();
        check("t1_lat_c1_valid", 64'(bus.tx_valid), 64'd0);
        bus.rec_din = R1;
        tick();
        check("t1_lat_c2_valid", 64'(bus.tx_valid), 64'd1);
        check("t1_lat_c2_data", 64'(bus.tx_data), 64'hA5);
        bus.rec_din = R2;
        tick();
        bus.rec_valid = 1'b0;
        tick();
        tick();
        pulse_done();
        wait_frame("t1", b0, b1);

        // Empty run.
        exp_clear();
        exp_hdr();
        exp_trl(16'd0, 1'b0);
        pulse_done();
        wait_frame("t2", b0, b1);
        check("t2_busy_at_fd", 64'(b0), 64'd1);
        check("t2_busy_after_fd", 64'(b1), 64'd0);

        // Link stall in the middle of a record.
        exp_clear();
        exp_hdr();
        exp_rec(R1);
        exp_trl(16'd1, 1'b0);
        send_rec(R1, 1'b1);
        wait_bytes("t3", 5);
        bus.tx_ready = 1'b0;
        d0 = bus.tx_data;
        v0 = bus.tx_valid;
        check("t3_stall_valid", 64'(v0), 64'd1);
        check("t3_stall_byte", 64'(d0), 64'(exp_q[5]));
        bad = 0;
        repeat (20) begin
            tick();
            if (bus.tx_data !== d0 || bus.tx_valid !== v0) bad++;
        end
        check("t3_frozen", 64'(bad), 64'd0);
        check("t3_no_accept", 64'(got_q.size()), 64'd5);
        bus.tx_ready = 1'b1;
        wait_frame("t3", b0, b1);

        // FIFO overflow: 18 pushes against a stalled link.
        exp_clear();
        exp_hdr();
        for (int i = 0; i < 16; i++) exp_rec(pat(i));
        exp_trl(16'd16, 1'b1);
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            bus.rec_din   = pat(i);
            bus.rec_valid = 1'b1;
            tick();
        end
        bus.rec_valid = 1'b0;
        tick();
        check("t4_overflow_set", 64'(bus.overflow), 64'd1);
        pulse_done();
        bus.tx_ready = 1'b1;
        wait_frame("t4", b0, b1);
        check("t4_overflow_clear", 64'(bus.overflow), 64'd0);

        // match_done coincides with the fourth record of a burst.
        exp_clear();
        exp_hdr();
        for (int i = 20; i < 24; i++) exp_rec(pat(i));
        exp_trl(16'd4, 1'b0);
        for (int i = 20; i < 24; i++) begin
            bus.rec_din    = pat(i);
            bus.rec_valid  = 1'b1;
            bus.match_done = (i == 23);
            tick();
        end
        bus.rec_valid  = 1'b0;
        bus.match_done = 1'b0;
        wait_frame("t5", b0, b1);

        // Reset during record byte 3, then a clean new frame.
        exp_clear();
        send_rec(pat(40), 1'b1);
        wait_bytes("t6", 5);
        rst = 1'b1;
        tick();
        check("t6_rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        check("t6_rst_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;
        repeat (3) tick();
        check("t6_idle_after_rst", 64'(bus.tx_valid), 64'd0);
        exp_clear();
        exp_hdr();
        exp_rec(pat(41));
        exp_trl(16'd1, 1'b0);
        send_rec(pat(41), 1'b1);
        wait_frame("t6", b0, b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
